// File: rtl/keypad_scanner_pkg.sv
// Shared widths, index types and the keypad position -> CHIP-8 key map
// used by the 4x4 hex keypad scanner.
package keypad_scanner_pkg;

  localparam int ROW_W = 2;
  localparam int KEY_W = 4;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [KEY_W-1:0] key_t;

  // Position is {row, col}; returns the CHIP-8 value printed on that key.
  function automatic key_t key_of(input logic [3:0] pos);
    case (pos)
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hC;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hD;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hE;
      4'd12:   return 4'hA;
      4'd13:   return 4'h0;
      4'd14:   return 4'hB;
      4'd15:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side and CPU-side signals of the keypad scanner; the scanner is the
// master, the board/CPU side (or a bench) is the slave.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keypad_matrix;
  logic        key_down;
  key_t        key_code;

  modport master (
    input  col_n,
    output row_n,
    output keypad_matrix,
    output key_down,
    output key_code
  );

  modport slave (
    output col_n,
    input  row_n,
    input  keypad_matrix,
    input  key_down,
    input  key_code
  );

endinterface

// File: rtl/keypad_scanner_debounce.sv
// Debounce for a single key: the stable state flips only after
// DEBOUNCE_SCANS consecutive disagreeing samples; rise flags a 0->1 flip.
module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic raw,
  output logic stable,
  output logic rise
);

  logic [3:0] cnt_r;
  logic       stable_r;
  logic       flip_s;

  // Flip happens on the sample that completes the disagreeing run.
  always_comb begin
    flip_s = 1'b0;
    if (en && (raw != stable_r) && (cnt_r == 4'(DEBOUNCE_SCANS - 1))) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
  end

  // Count and stable state advance only when this key is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= 4'd0;
      stable_r <= 1'b0;
    end else if (en) begin
      if (raw == stable_r) begin
        cnt_r <= 4'd0;
      end else if (flip_s) begin
        stable_r <= raw;
        cnt_r    <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end else begin
      cnt_r    <= cnt_r;
      stable_r <= stable_r;
    end
  end

  assign stable = stable_r;
  assign rise   = flip_s & raw;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sequencer, column synchroniser, 16 debouncers
// and a key-press event encoder feeding the CPU's keypad_matrix input.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_r;
  row_t             row_r;
  logic [3:0]       row_n_r;
  logic [3:0]       sync1_r;
  logic [3:0]       col_sync_r;
  logic             sample_s;
  logic [15:0]      en_s;
  logic [15:0]      raw_s;
  logic [15:0]      stable_s;
  logic [15:0]      rise_s;
  logic [15:0]      matrix_s;
  key_t             code_s;
  logic             key_down_r;
  key_t             key_code_r;

  assign sample_s = (div_r == DIV_W'(SCAN_DIV - 1));

  // Row sequencer: the one-hot-low drive rotates alongside the row index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r   <= '0;
      row_r   <= 2'd0;
      row_n_r <= 4'b1110;
    end else if (sample_s) begin
      div_r   <= '0;
      row_r   <= row_r + 2'd1;
      row_n_r <= {row_n_r[2:0], row_n_r[3]};
    end else begin
      div_r   <= div_r + DIV_W'(1);
      row_r   <= row_r;
      row_n_r <= row_n_r;
    end
  end

  // Two-flop synchroniser; idle columns read as pulled-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      sync1_r    <= kp.col_n;
      col_sync_r <= sync1_r;
    end
  end

  // Only the four keys of the driven row see an enable on the sample cycle.
  always_comb begin
    en_s  = 16'h0000;
    raw_s = 16'h0000;
    for (int p = 0; p < 16; p++) begin
      en_s[p]  = sample_s && (row_r == row_t'(p / 4));
      raw_s[p] = ~col_sync_r[p % 4];
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_key
    keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (en_s[g]),
      .raw    (raw_s[g]),
      .stable (stable_s[g]),
      .rise   (rise_s[g])
    );
  end

  // Reorder debouncer outputs from matrix position to CHIP-8 key value.
  always_comb begin
    matrix_s = 16'h0000;
    for (int p = 0; p < 16; p++) begin
      matrix_s[key_of(4'(p))] = stable_s[p];
    end
  end

  // Lowest column wins when several keys of the sampled row rise together.
  always_comb begin
    code_s = key_code_r;
    for (int c = 3; c >= 0; c--) begin
      if (rise_s[{row_r, 2'(c)}]) begin
        code_s = key_of({row_r, 2'(c)});
      end else begin
        code_s = code_s;
      end
    end
  end

  // Event outputs register on the same edge that flips the stable state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_down_r <= 1'b0;
      key_code_r <= 4'h0;
    end else begin
      key_down_r <= |rise_s;
      key_code_r <= code_s;
    end
  end

  assign kp.row_n         = row_n_r;
  assign kp.keypad_matrix = matrix_s;
  assign kp.key_down      = key_down_r;
  assign kp.key_code      = key_code_r;

endmodule
